// File: rtl/tc_ram_block_mover.sv
// tc_ram_block_mover: single-command copy/fill engine driving a TC-style byte RAM.
// Rev 1.0 -- copy costs 3 cycles per byte (load, wait, save); fill costs 1 cycle per byte.
`default_nettype none

module tc_ram_block_mover #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] src,
   input  logic [ADDR_W-1:0] dst,
   input  logic [ADDR_W-1:0] len,
   input  logic [DATA_W-1:0] fill_value,
   output logic              busy,
   output logic              done,
   output logic              ram_load,
   output logic              ram_save,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_in,
   input  logic [DATA_W-1:0] ram_out
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_WAIT  = 3'd2,
      S_WRITE = 3'd3,
      S_FILL  = 3'd4,
      S_FIN   = 3'd5
   } state_t;

   state_t            state, state_n;
   logic [ADDR_W-1:0] src_q, dst_q, len_q;
   logic [DATA_W-1:0] fill_q;
   logic [ADDR_W-1:0] idx, idx_n, idx_inc;
   logic [ADDR_W-1:0] addr_n;
   logic [DATA_W-1:0] in_n;
   logic              accept;

   // Outputs are registered against the next state, so each state's strobes
   // and address are visible during the cycle spent in that state.
   always_comb begin
      state_n = state;
      idx_n   = idx;
      idx_inc = idx + ADDR_W'(1);
      addr_n  = ram_address;
      in_n    = ram_in;
      accept  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               accept = 1'b1;
               idx_n  = '0;
               if (len == '0) begin
                  state_n = S_FIN;
               end else if (mode) begin
                  state_n = S_FILL;
                  addr_n  = dst;
                  in_n    = fill_value;
               end else begin
                  state_n = S_READ;
                  addr_n  = src;
               end
            end
         end
         S_READ: state_n = S_WAIT;
         S_WAIT: begin
            // ram_in doubles as the data register: read data lands here directly.
            state_n = S_WRITE;
            addr_n  = dst_q + idx;
            in_n    = ram_out;
         end
         S_WRITE: begin
            idx_n = idx_inc;
            if (idx_inc == len_q) begin
               state_n = S_FIN;
            end else begin
               state_n = S_READ;
               addr_n  = src_q + idx_inc;
            end
         end
         S_FILL: begin
            idx_n = idx_inc;
            if (idx_inc == len_q) begin
               state_n = S_FIN;
            end else begin
               addr_n = dst_q + idx_inc;
               in_n   = fill_q;
            end
         end
         S_FIN:   state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         idx         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         ram_load    <= 1'b0;
         ram_save    <= 1'b0;
         ram_address <= '0;
         ram_in      <= '0;
      end else begin
         state       <= state_n;
         idx         <= idx_n;
         busy        <= (state_n == S_READ) || (state_n == S_WAIT) ||
                        (state_n == S_WRITE) || (state_n == S_FILL);
         done        <= (state_n == S_FIN);
         ram_load    <= (state_n == S_READ);
         ram_save    <= (state_n == S_WRITE) || (state_n == S_FILL);
         ram_address <= addr_n;
         ram_in      <= in_n;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         src_q  <= '0;
         dst_q  <= '0;
         len_q  <= '0;
         fill_q <= '0;
      end else if (accept) begin
         src_q  <= src;
         dst_q  <= dst;
         len_q  <= len;
         fill_q <= fill_value;
      end
   end

endmodule

`default_nettype wire
